ps2_kb_cmd_sched: RTL and testbench

Host-to-keyboard command scheduler that owns the PS/2 transmit path. It arbitrates between three requesters:
- power-up keyboard init
- CPU byte writes to the SCANCODE register
- LED updates

It sequences each command onto the PS/2 writer, then consumes the keyboard's ACK, RESEND and BAT replies from the receive stream, with retries and timeouts. Bytes it consumes are flagged so the scancode translator ignores them.

---
 rtl/ps2_kb_cmd_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_ps2_kb_cmd_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_cmd_sched.sv
// PS/2 host-to-keyboard command scheduler: arbitrates init, CPU and LED
// commands onto the PS/2 writer and consumes the keyboard's ACK/RESEND/BAT replies.
module ps2_kb_cmd_sched #(
    parameter int ACK_TIMEOUT = 560000,
    parameter int BAT_TIMEOUT = 28000000,
    parameter int MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_data,
    input  logic       cpu_load,
    input  logic       led_req,
    input  logic [2:0] led_val,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_busy,
    input  logic       tx_error,
    input  logic       rx_strobe,
    input  logic [7:0] rx_code,
    output logic       rx_swallow,
    output logic       cpu_busy,
    output logic       init_done,
    output logic       cmd_error
);

    localparam int TW = $clog2(BAT_TIMEOUT);
    localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0] ACK_LAST    = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LAST    = TW'(BAT_TIMEOUT - 1);
    localparam logic [TW-1:0] TX_WIN_LAST = TW'(15);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] CMD_LEDS  = 8'hED;
    localparam logic [7:0] KB_ACK    = 8'hFA;
    localparam logic [7:0] KB_RESEND = 8'hFE;
    localparam logic [7:0] KB_BAT_OK = 8'hAA;
    localparam logic [7:0] KB_BAT_NG = 8'hFC;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_TXWAIT, ST_ACKWAIT, ST_BATWAIT, ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEQ_INIT, SEQ_CPU, SEQ_LED
    } seq_t;

    state_t        state_q, state_d;
    seq_t          seq_q, seq_d;
    logic          byte_idx_q, byte_idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          seen_busy_q, seen_busy_d;
    logic          init_pending_q, init_pending_d;
    logic          cpu_pending_q, cpu_pending_d;
    logic          led_pending_q, led_pending_d;
    logic          led_again_q, led_again_d;
    logic [7:0]    cpu_byte_q, cpu_byte_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_load_q, tx_load_d;
    logic          init_done_q, init_done_d;
    logic          cmd_error_q, cmd_error_d;
    logic          do_retry;
    logic          led_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            seq_q          <= SEQ_INIT;
            byte_idx_q     <= 1'b0;
            retry_q        <= '0;
            timer_q        <= '0;
            seen_busy_q    <= 1'b0;
            init_pending_q <= 1'b1;
            cpu_pending_q  <= 1'b0;
            led_pending_q  <= 1'b0;
            led_again_q    <= 1'b0;
            cpu_byte_q     <= 8'h00;
            tx_data_q      <= 8'h00;
            tx_load_q      <= 1'b0;
            init_done_q    <= 1'b0;
            cmd_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            byte_idx_q     <= byte_idx_d;
            retry_q        <= retry_d;
            timer_q        <= timer_d;
            seen_busy_q    <= seen_busy_d;
            init_pending_q <= init_pending_d;
            cpu_pending_q  <= cpu_pending_d;
            led_pending_q  <= led_pending_d;
            led_again_q    <= led_again_d;
            cpu_byte_q     <= cpu_byte_d;
            tx_data_q      <= tx_data_d;
            tx_load_q      <= tx_load_d;
            init_done_q    <= init_done_d;
            cmd_error_q    <= cmd_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        byte_idx_d     = byte_idx_q;
        retry_d        = retry_q;
        timer_d        = timer_q;
        seen_busy_d    = seen_busy_q;
        init_pending_d = init_pending_q;
        cpu_pending_d  = cpu_pending_q;
        led_pending_d  = led_pending_q;
        led_again_d    = led_again_q;
        cpu_byte_d     = cpu_byte_q;
        tx_data_d      = tx_data_q;
        tx_load_d      = 1'b0;
        init_done_d    = init_done_q;
        cmd_error_d    = cmd_error_q;
        do_retry       = 1'b0;
        led_active     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                retry_d    = '0;
                byte_idx_d = 1'b0;
                if (init_pending_q) begin
                    seq_d   = SEQ_INIT;
                    state_d = ST_LOAD;
                end else if (cpu_pending_q) begin
                    seq_d       = SEQ_CPU;
                    state_d     = ST_LOAD;
                    cmd_error_d = 1'b0;
                end else if (led_pending_q) begin
                    seq_d   = SEQ_LED;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                seen_busy_d = 1'b0;
                state_d     = ST_TXWAIT;
            end
            ST_TXWAIT: begin
                if (!seen_busy_q) begin
                    if (tx_busy) begin
                        seen_busy_d = 1'b1;
                    end else if (timer_q == TX_WIN_LAST) begin
                        do_retry = 1'b1;
                    end
                end else if (!tx_busy) begin
                    if (tx_error) begin
                        do_retry = 1'b1;
                    end else begin
                        state_d = ST_ACKWAIT;
                    end
                end
            end
            ST_ACKWAIT: begin
                if (rx_strobe && rx_code == KB_ACK) begin
                    if (seq_q == SEQ_INIT) begin
                        state_d = ST_BATWAIT;
                    end else if (seq_q == SEQ_LED && !byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        retry_d    = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (rx_strobe && rx_code == KB_RESEND) begin
                    do_retry = 1'b1;
                end else if (timer_q == ACK_LAST) begin
                    do_retry = 1'b1;
                end
            end
            ST_BATWAIT: begin
                if (rx_strobe && rx_code == KB_BAT_OK) begin
                    init_done_d = 1'b1;
                    state_d     = ST_DONE;
                end else if ((rx_strobe && rx_code == KB_BAT_NG) || timer_q == BAT_LAST) begin
                    cmd_error_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                case (seq_q)
                    SEQ_INIT: init_pending_d = 1'b0;
                    SEQ_CPU:  cpu_pending_d  = 1'b0;
                    default: begin
                        led_pending_d = led_again_q;
                        led_again_d   = 1'b0;
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_retry) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RW'(1);
                state_d = ST_LOAD;
            end else begin
                cmd_error_d = 1'b1;
                state_d     = ST_DONE;
            end
        end

        // LOAD always exits after one cycle, so entering it is the single load point
        if (state_d == ST_LOAD) begin
            tx_load_d = 1'b1;
            case (seq_d)
                SEQ_INIT: tx_data_d = CMD_RESET;
                SEQ_CPU:  tx_data_d = cpu_byte_q;
                default:  tx_data_d = byte_idx_d ? {5'b0, led_val} : CMD_LEDS;
            endcase
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == ST_TXWAIT || state_q == ST_ACKWAIT || state_q == ST_BATWAIT) begin
            timer_d = timer_q + TW'(1);
        end

        if (cpu_load) begin
            if (!cpu_pending_q) begin
                cpu_pending_d = 1'b1;
                cpu_byte_d    = cpu_data;
            end else begin
                cmd_error_d = 1'b1;
            end
        end

        // A request landing while an LED sequence owns the writer must re-run it afterwards
        led_active = (seq_d == SEQ_LED) && (state_d != ST_IDLE);
        if (led_req) begin
            if (led_active) begin
                led_again_d = 1'b1;
            end else begin
                led_pending_d = 1'b1;
            end
        end
    end

    assign rx_swallow = rx_strobe &&
                        ((state_q == ST_ACKWAIT && (rx_code == KB_ACK || rx_code == KB_RESEND)) ||
                         (state_q == ST_BATWAIT && (rx_code == KB_BAT_OK || rx_code == KB_BAT_NG)));

    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign cpu_busy  = cpu_pending_q;
    assign init_done = init_done_q;
    assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_ps2_kb_cmd_sched.sv
// Directed-plus-random bench for ps2_kb_cmd_sched with a PS/2 writer model
// and a keyboard reply script derived from the command protocol rules.
module tb_ps2_kb_cmd_sched;

    localparam int ACK_T = 300;
    localparam int BAT_T = 1500;
    localparam int RETR  = 3;
    localparam int BUSY_CYCLES = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_load = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy = 1'b0;
    logic       tx_error = 1'b0;
    logic       rx_strobe = 1'b0;
    logic [7:0] rx_code = 8'h00;
    logic       rx_swallow;
    logic       cpu_busy;
    logic       init_done;
    logic       cmd_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_loads = 0;
    int wr_done = 0;
    int wr_fail = 0;
    logic [7:0] load_q[$];
    int         load_cyc_q[$];

    ps2_kb_cmd_sched #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRIES(RETR)) dut (
        .clk(clk), .rst(rst), .cpu_data(cpu_data), .cpu_load(cpu_load),
        .led_req(led_req), .led_val(led_val), .tx_data(tx_data), .tx_load(tx_load),
        .tx_busy(tx_busy), .tx_error(tx_error), .rx_strobe(rx_strobe), .rx_code(rx_code),
        .rx_swallow(rx_swallow), .cpu_busy(cpu_busy), .init_done(init_done),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writer model: busy rises a few cycles after each load, stays up 100 cycles
    initial begin
        forever begin
            @(negedge clk);
            tx_error = 1'b0;
            if (tx_load) begin
                load_q.push_back(tx_data);
                load_cyc_q.push_back(cyc);
                n_loads++;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_busy = 1'b1;
                repeat (BUSY_CYCLES) @(negedge clk);
                if (wr_fail > 0) begin
                    tx_error = 1'b1;
                    wr_fail--;
                end
                tx_busy = 1'b0;
                wr_done++;
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_load(input string tag, input logic [7:0] exp, input int bound, output int lc);
        int n = 0;
        lc = -1;
        while (load_q.size() == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, (load_q.size() != 0), 1);
        if (load_q.size() != 0) begin
            lc = load_cyc_q.pop_front();
            check({tag, "_byte"}, load_q.pop_front(), exp);
            $display("load %s byte=%02h cyc=%0d", tag, exp, lc);
        end
    endtask

    task automatic wait_tx_done(input string tag);
        int n = 0;
        while (wr_done != n_loads && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (wr_done != n_loads) check({tag, "_txdone"}, wr_done, n_loads);
    endtask

    task automatic kb_reply(input string tag, input logic [7:0] code, input logic exp_sw);
        @(negedge clk);
        rx_code = code;
        rx_strobe = 1'b1;
        #1;
        check({tag, "_swallow"}, rx_swallow, exp_sw);
        $display("reply %s code=%02h swallow=%0b", tag, code, rx_swallow);
        @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    // One command byte answered with n_resend RESENDs then an ACK (n_resend <= RETR)
    task automatic run_cmd(input string tag, input logic [7:0] b, input int n_resend);
        int lc;
        for (int a = 0; a <= n_resend; a++) begin
            expect_load(tag, b, 200, lc);
            wait_tx_done(tag);
            repeat ($urandom_range(1, 40)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) kb_reply({tag, "_noise"}, 8'($urandom_range(1, 127)), 1'b0);
            if (a < n_resend) kb_reply({tag, "_fe"}, 8'hFE, 1'b1);
            else kb_reply({tag, "_fa"}, 8'hFA, 1'b1);
        end
    endtask

    task automatic pulse_cpu(input logic [7:0] b);
        cpu_data = b;
        cpu_load = 1'b1;
        @(negedge clk);
        cpu_load = 1'b0;
    endtask

    task automatic wait_cpu_idle(input string tag, input int bound);
        int n = 0;
        while (cpu_busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cpu_busy"}, cpu_busy, 0);
    endtask

    initial begin
        int lc, req_cyc, prev_lc;
        logic [7:0] b, b2;
        logic [2:0] v;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_load", tx_load, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_cpu_busy", cpu_busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_cmd_error", cmd_error, 0);
        rst = 1'b0;

        // Power-up init: FF, ACK, BAT ok
        expect_load("init", 8'hFF, 20, lc);
        wait_tx_done("init");
        repeat ($urandom_range(1, 40)) @(negedge clk);
        kb_reply("init_ack", 8'hFA, 1'b1);
        repeat ($urandom_range(1, 100)) @(negedge clk);
        kb_reply("init_bat", 8'hAA, 1'b1);
        @(negedge clk);
        check("init_done", init_done, 1);
        check("init_err", cmd_error, 0);
        check("init_no_extra", load_q.size(), 0);

        // LED update with the 2-cycle request-to-load latency
        repeat (5) @(negedge clk);
        led_val = 3'b101;
        req_cyc = cyc;
        led_req = 1'b1;
        @(negedge clk);
        led_req = 1'b0;
        expect_load("led_cmd", 8'hED, 20, lc);
        check("led_latency", lc - req_cyc, 2);
        wait_tx_done("led_cmd");
        kb_reply("led_cmd_fa", 8'hFA, 1'b1);
        run_cmd("led_val", 8'h05, 0);
        repeat (40) @(negedge clk);
        check("led_no_rerun", load_q.size(), 0);

        // CPU F4 with two RESENDs
        pulse_cpu(8'hF4);
        check("f4_busy", cpu_busy, 1);
        run_cmd("f4", 8'hF4, 2);
        repeat (3) @(negedge clk);
        check("f4_cpu_busy", cpu_busy, 0);
        check("f4_err", cmd_error, 0);

        // Writer error on first attempt forces a resend of the same byte
        b = 8'($urandom_range(0, 255));
        wr_fail = 1;
        pulse_cpu(b);
        expect_load("txerr_1", b, 20, lc);
        wait_tx_done("txerr_1");
        run_cmd("txerr_2", b, 0);
        repeat (3) @(negedge clk);
        check("txerr_err", cmd_error, 0);
        wait_cpu_idle("txerr", 10);

        // No reply at all: 1 + RETR loads spaced by at least the ACK timeout
        pulse_cpu(8'hED);
        prev_lc = -1;
        for (int i = 0; i <= RETR; i++) begin
            expect_load($sformatf("noreply_%0d", i), 8'hED, 700, lc);
            if (i > 0) check($sformatf("noreply_gap_%0d", i), (lc - prev_lc >= ACK_T), 1);
            prev_lc = lc;
        end
        wait_cpu_idle("noreply", 700);
        check("noreply_err", cmd_error, 1);
        repeat (20) @(negedge clk);
        check("noreply_no_extra", load_q.size(), 0);

        // Scancode during ACKWAIT passes through; new CPU sequence clears error
        b = 8'($urandom_range(0, 255));
        pulse_cpu(b);
        expect_load("scan", b, 20, lc);
        check("scan_err_cleared", cmd_error, 0);
        wait_tx_done("scan");
        kb_reply("scan_1c", 8'h1C, 1'b0);
        kb_reply("scan_fa", 8'hFA, 1'b1);
        wait_cpu_idle("scan", 10);

        // Simultaneous LED and CPU requests, plus an ignored second CPU write
        b = 8'($urandom_range(0, 255));
        b2 = ~b;
        v = 3'($urandom_range(0, 7));
        led_val = v;
        cpu_data = b;
        cpu_load = 1'b1;
        led_req = 1'b1;
        @(negedge clk);
        cpu_load = 1'b0;
        led_req = 1'b0;
        expect_load("both_cpu", b, 20, lc);
        pulse_cpu(b2);
        check("both_second_err", cmd_error, 1);
        check("both_busy", cpu_busy, 1);
        wait_tx_done("both_cpu");
        kb_reply("both_cpu_fa", 8'hFA, 1'b1);
        run_cmd("both_led_cmd", 8'hED, 0);
        run_cmd("both_led_val", {5'b0, v}, 0);
        repeat (40) @(negedge clk);
        check("both_no_extra", load_q.size(), 0);
        check("both_cpu_busy", cpu_busy, 0);
        check("both_err", cmd_error, 1);

        // Reset in ACKWAIT restarts init; BAT failure sets error
        pulse_cpu(8'h42);
        expect_load("rst_mid", 8'h42, 20, lc);
        wait_tx_done("rst_mid");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_busy", cpu_busy, 0);
        check("rst_mid_err", cmd_error, 0);
        check("rst_mid_done", init_done, 0);
        rst = 1'b0;
        expect_load("reinit", 8'hFF, 20, lc);
        wait_tx_done("reinit");
        kb_reply("reinit_ack", 8'hFA, 1'b1);
        repeat ($urandom_range(1, 100)) @(negedge clk);
        kb_reply("reinit_fc", 8'hFC, 1'b1);
        @(negedge clk);
        check("reinit_err", cmd_error, 1);
        check("reinit_done", init_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
